// File: rtl/mux_stream_nx1.sv
// N-to-1 stream multiplexer with fixed-select or round-robin grant and a
// single registered output slot.
module mux_stream_nx1 #(
    parameter int N  = 3,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    input  logic           out_ready
);

    // Handshake: a word moves on any port only on a rising edge where its
    // valid and ready are both high; valid never waits on ready, and a
    // presented output word holds until it is accepted.

    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] grant_idx;
    logic          grant_any;
    logic [N-1:0]  grant;
    logic          load_en;
    logic          transfer;

    function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int k);
        int t;
        t = (int'(base) + k) % N;
        return SW'(t);
    endfunction

    // Mode 0 grants regardless of validity; mode 1 searches upward from the
    // channel after the last one served.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        if (!mode) begin
            grant_any = 1'b1;
            if (32'(sel) >= N) grant_idx = SW'(N - 1);
            else               grant_idx = sel;
        end else begin
            for (int k = N; k >= 1; k--) begin
                if (in_valid[wrap_idx(rr_ptr, k)]) begin
                    grant_any = 1'b1;
                    grant_idx = wrap_idx(rr_ptr, k);
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    assign load_en  = ~out_valid | out_ready;
    assign in_ready = grant & {N{load_en}};
    assign transfer = load_en & grant_any & in_valid[grant_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SW'(N - 1);
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant_idx)*W +: W];
            out_ch    <= grant_idx;
            if (mode) rr_ptr <= grant_idx;
        end else if (load_en) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_stream_nx1.sv
// Bench for mux_stream_nx1: directed scenarios plus random traffic, checked
// by a transaction-level model feeding an expected queue.
module tb_mux_stream_nx1;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int SW = 2;
    localparam int EW = SW + W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           mode = 1'b0;
    logic [SW-1:0]  sel = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_ready = 1'b0;

    mux_stream_nx1 #(.N(N), .W(W), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int m_last = N - 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
        return d;
    endfunction

    // One clock of stimulus; the model decides what the mux must accept
    // from the slot occupancy (words still owed downstream) and priority order.
    task automatic cycle(input logic r, input logic m, input logic [SW-1:0] s,
                         input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
        int     win;
        bit     has;
        bit     can_load;
        int     order[$];
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        rst_n = r; mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        if (!r) begin
            exp_q.delete();
            m_last = N - 1;
            return;
        end
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        can_load = (exp_q.size() == 0) || ordy;
        has = 0;
        win = 0;
        if (!m) begin
            has = 1;
            win = (int'(s) >= N) ? N - 1 : int'(s);
        end else begin
            for (int k = 1; k <= N; k++) order.push_back((m_last + k) % N);
            foreach (order[i]) if (!has && v[order[i]]) begin
                has = 1;
                win = order[i];
            end
        end
        exp_rdy = '0;
        if (has && can_load) exp_rdy[win] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (has && can_load && v[win]) begin
            exp_q.push_back({SW'(win), d[win*W +: W]});
            if (m) m_last = win;
        end
    endtask

    task automatic check_reset_outs();
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_ch", 64'(out_ch), 64'(0));
    endtask

    // Monitor: a word is consumed at the coming edge when valid and ready
    // are both high after the driver has settled.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_word: got %0h expected none at %0t", {out_ch, out_data}, $time);
                end else begin
                    check("out_word", 64'({out_ch, out_data}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int drain;
        cycle(0, 0, 0, 0, '0, 0);
        cycle(0, 0, 0, 0, '0, 0);
        check_reset_outs();

        // fixed select, then out-of-range select
        cycle(1, 0, 2'd1, 3'b111, {8'hCC, 8'hBB, 8'hAA}, 1);
        cycle(1, 0, 2'd3, 3'b100, {8'h5A, 8'h11, 8'h22}, 1);
        cycle(1, 0, 2'd0, 3'b000, rand_data(), 1);

        // round robin from reset: 0,1,2,0,1,2 back to back
        cycle(0, 1, 0, 0, '0, 0);
        check_reset_outs();
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 3'b111, rand_data(), 1);
        // downstream stall, then release
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 3'b111, rand_data(), 0);
        cycle(1, 1, 0, 3'b111, rand_data(), 1);
        cycle(1, 1, 0, 3'b000, '0, 1);

        // ptr at 0, channels 0 and 2 requesting
        cycle(1, 1, 0, 3'b001, rand_data(), 1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 3'b101, rand_data(), 1);

        // reset while a word is held
        cycle(1, 0, 0, 3'b111, rand_data(), 0);
        cycle(1, 0, 0, 3'b111, rand_data(), 0);
        cycle(0, 0, 0, 3'b111, rand_data(), 0);
        check_reset_outs();
        cycle(1, 1, 0, 3'b111, rand_data(), 1);
        cycle(1, 1, 0, 3'b000, '0, 1);

        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
                  SW'($urandom_range(0, 3)), N'($urandom_range(0, 7)),
                  rand_data(), ($urandom_range(0, 3) != 0));
        end

        drain = 0;
        while (exp_q.size() != 0 && drain < 10) begin
            cycle(1, 0, 0, 3'b000, '0, 1);
            drain++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_stream_nx1.md
MUX_STREAM_NX1 -- requirements
Module: mux_stream_nx1

Interface
REQ-001 Parameter N, default 3: number of input channels, legal range 2..8.
REQ-002 Parameter W, default 8: data width per channel, legal range 1..64.
REQ-003 Parameter SW, default $clog2(N): width of select and channel-ID fields.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 mode  input  1  0 = fixed select (sel), 1 = round-robin arbitration.
REQ-007 sel  input  SW  channel select, used only when mode = 0.
REQ-008 in_valid  input  N  per-channel valid; bit i belongs to channel i.
REQ-009 in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
REQ-010 in_ready  output  N  per-channel ready; a transfer occurs on channel i when in_valid[i] & in_ready[i].
REQ-011 out_valid  output  1  registered output holds valid data.
REQ-012 out_data  output  W  registered output data.
REQ-013 out_ch  output  SW  index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accepts out_data when out_valid & out_ready.

Function
REQ-015 Output stage SHALL be a single register slot: load_en = ~out_valid | out_ready.
REQ-016 At most one in_ready bit SHALL be high in any cycle: in_ready = grant & {N{load_en}}.
REQ-017 Mode 0: grant SHALL be one-hot on sel when sel < N; when sel >= N, grant SHALL select channel N-1.
REQ-018 Mode 0: grant SHALL be asserted regardless of in_valid[sel]; no transfer occurs unless that channel is valid.
REQ-019 Mode 1: grant SHALL go to the first valid channel found searching upward from (rr_ptr+1) mod N, wrapping at N-1 -> 0; grant = 0 when in_valid = 0.
REQ-020 rr_ptr (SW bits) SHALL update to the granted index only on a transfer cycle in mode 1; in mode 0 it SHALL hold.
REQ-021 On a transfer cycle, out_data <= selected in_data, out_ch <= granted index, and out_valid <= 1, all on the same edge.
REQ-022 When load_en = 1 and no transfer occurs, out_valid SHALL clear to 0; out_data and out_ch SHALL hold.
REQ-023 When out_valid = 1 and out_ready = 0, out_valid, out_data and out_ch SHALL hold and in_ready SHALL be all-zero.
REQ-024 Simultaneous downstream accept and upstream transfer SHALL sustain one word per clock with no bubble.
REQ-025 Latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-026 A change of mode or sel SHALL affect only the grant of the current cycle; out_valid, out_data, out_ch and rr_ptr SHALL be unaffected.
REQ-027 in_ready SHALL depend combinationally on in_valid (mode 1), mode, sel, out_valid and out_ready; no other output SHALL be combinational.

Reset
REQ-028 While rst_n = 0 at a rising edge: out_valid <= 0, out_data <= 0, out_ch <= 0, rr_ptr <= N-1.
REQ-029 During reset cycles no transfer SHALL be recorded; in_ready MAY assert but SHALL have no effect on state.
REQ-030 Reset asserted while out_valid = 1 and out_ready = 0 SHALL discard the held word; out_valid = 0 in the first cycle after rst_n rises.
REQ-031 After reset in mode 1, channel 0 SHALL have highest priority.

Verification (N=3, W=8)
REQ-032 Mode 0, sel=1, in_valid=3'b111, data {0xCC,0xBB,0xAA}, out_ready=1 -> in_ready=3'b010; next cycle out_valid=1, out_data=0xBB, out_ch=1.
REQ-033 Mode 0, sel=3, in_valid=3'b100, data[2]=0x5A -> in_ready=3'b100; next cycle out_data=0x5A, out_ch=2.
REQ-034 Mode 1 after reset, in_valid=3'b111 held, out_ready=1, 6 cycles -> out_ch sequence 0,1,2,0,1,2 with no bubbles.
REQ-035 Mode 1, out_ready=0 for 3 cycles after the first transfer -> in_ready=0 and out_data/out_ch stable; on out_ready=1 the next channel in order is accepted the same cycle.
REQ-036 Mode 1, in_valid=3'b101, rr_ptr=0 -> grant ch2 then ch0 then ch2; ch1 is never granted.
REQ-037 rst_n=0 for one cycle while out_valid=1, out_ready=0 -> out_valid=0, out_data=0, out_ch=0; next mode-1 grant with in_valid=3'b111 is ch0.
